// File: rtl/gpu_cmd_sequencer_pkg.sv
// Shared widths, opcodes and sequencer state encoding for the GPU command path.
package gpu_pkg;

    localparam int CMD_W   = 29;
    localparam int OPC_W   = 4;
    localparam int PARAM_W = 25;
    localparam int TMO_W   = 21;

    typedef enum logic [OPC_W-1:0] {
        OP_CLEAR     = 4'h0,
        OP_SET_XY1   = 4'h1,
        OP_SET_XY2   = 4'h2,
        OP_SET_RAD   = 4'h3,
        OP_DRAW_LINE = 4'h4
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/gpu_cmd_sequencer_if.sv
// Host-write and decoder-issue signals of the command sequencer.
interface gpu_cmd_sequencer_if #(
    parameter int DEPTH = 8
);
    import gpu_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 wr_en_i;
    logic [CMD_W-1:0]     wr_data_i;
    logic                 flush_i;
    logic                 full_o;
    logic [CNT_W-1:0]     count_o;
    logic [OPC_W-1:0]     opcode_o;
    logic [PARAM_W-1:0]   parameters_o;
    logic                 command_o;
    logic                 draw_done_i;
    logic                 busy_o;
    logic                 overflow_o;
    logic                 timeout_o;

    modport master (
        output wr_en_i, wr_data_i, flush_i, draw_done_i,
        input  full_o, count_o, opcode_o, parameters_o, command_o,
               busy_o, overflow_o, timeout_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, flush_i, draw_done_i,
        output full_o, count_o, opcode_o, parameters_o, command_o,
               busy_o, overflow_o, timeout_o
    );

endinterface

// File: rtl/gpu_cmd_sequencer_fifo.sv
// Command word FIFO: registered count, no write-to-read bypass, flush beats push/pop.
module gpu_cmd_fifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = CMD_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [W-1:0]     wdata_i,
    output logic [W-1:0]     rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign push_ok    = push_i && !full_o && !flush_i;
    assign pop_ok     = pop_i && !empty_o && !flush_i;
    // A flushed push is discarded anyway, so it does not count as dropped.
    assign overflow_o = push_i && full_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/gpu_cmd_sequencer.sv
// Pops queued command words, strobes them to the decoder, stalls on DRAW_LINE.
//   state     | meaning
//   IDLE      | waiting for a queued word; pops and latches it
//   ISSUE     | command_o high for one cycle
//   WAIT_DONE | line engine busy; watchdog running
module gpu_cmd_sequencer
    import gpu_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1048576
) (
    input  logic                 clk,
    input  logic                 rst,
    gpu_cmd_sequencer_if.slave   bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    seq_state_t           state_q, state_d;
    logic [OPC_W-1:0]     opcode_q, opcode_d;
    logic [PARAM_W-1:0]   param_q, param_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 timeout_q, timeout_d;
    logic                 overflow_q;

    logic                 pop;
    logic [CMD_W-1:0]     head;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;
    logic                 ovf_pulse;

    gpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (bus.wr_en_i),
        .pop_i      (pop),
        .flush_i    (bus.flush_i),
        .wdata_i    (bus.wr_data_i),
        .rdata_o    (head),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty),
        .overflow_o (ovf_pulse)
    );

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        param_d   = param_q;
        tmo_d     = tmo_q;
        timeout_d = timeout_q;
        pop       = 1'b0;
        if (bus.flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!empty) begin
                        pop      = 1'b1;
                        opcode_d = head[CMD_W-1:PARAM_W];
                        param_d  = head[PARAM_W-1:0];
                        state_d  = ISSUE;
                    end
                end
                ISSUE: begin
                    if (opcode_q == OP_DRAW_LINE) begin
                        state_d = WAIT_DONE;
                        tmo_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT_DONE: begin
                    // Done is checked first so a coincident timeout is not flagged.
                    if (bus.draw_done_i) begin
                        state_d = IDLE;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            opcode_q   <= '0;
            param_q    <= '0;
            tmo_q      <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            param_q    <= param_d;
            tmo_q      <= tmo_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_q | ovf_pulse;
        end
    end

    assign bus.full_o       = full;
    assign bus.count_o      = count;
    assign bus.opcode_o     = opcode_q;
    assign bus.parameters_o = param_q;
    assign bus.command_o    = (state_q == ISSUE);
    assign bus.busy_o       = (state_q != IDLE) || !empty;
    assign bus.overflow_o   = overflow_q;
    assign bus.timeout_o    = timeout_q;

endmodule
